// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clock_pkg
//  Description : Shared widths, range limits and alarm FSM encoding for the
//                clock keeper and its digit splitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package clock_pkg;

  localparam int HOURS_W    = 5;
  localparam int MINUTES_W  = 6;
  localparam int SECONDS_W  = 6;
  localparam int RING_CNT_W = 8;

  localparam logic [HOURS_W-1:0]   HOURS_MAX   = 5'd23;
  localparam logic [MINUTES_W-1:0] MINUTES_MAX = 6'd59;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    RINGING  = 2'b01,
    SILENCED = 2'b10
  } alarm_state_e;

  // True when an hours/minutes pair is a legal time of day.
  function automatic logic hm_valid(input logic [HOURS_W-1:0]   hours,
                                    input logic [MINUTES_W-1:0] minutes);
    return (hours <= HOURS_MAX) && (minutes <= MINUTES_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/clock_digit_split.sv
`default_nettype none
// ============================================================================
//  Module      : clock_digit_split
//  Description : Combinational binary (0-59) to two-digit BCD split.
//                Used for hours and minutes; the tens digit never exceeds 5.
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_digit_split #(
  parameter int W = 6
) (
  input  logic [W-1:0] bin_i,
  output logic [2:0]   tens_o,
  output logic [3:0]   units_o
);

  logic [6:0] bin_ext;

  assign bin_ext = 7'(bin_i);

  // Compare chain instead of a divider: the input range is tiny.
  always_comb begin
    tens_o  = 3'd0;
    units_o = 4'(bin_ext);
    if (bin_ext >= 7'd50) begin
      tens_o  = 3'd5;
      units_o = 4'(bin_ext - 7'd50);
    end else if (bin_ext >= 7'd40) begin
      tens_o  = 3'd4;
      units_o = 4'(bin_ext - 7'd40);
    end else if (bin_ext >= 7'd30) begin
      tens_o  = 3'd3;
      units_o = 4'(bin_ext - 7'd30);
    end else if (bin_ext >= 7'd20) begin
      tens_o  = 3'd2;
      units_o = 4'(bin_ext - 7'd20);
    end else if (bin_ext >= 7'd10) begin
      tens_o  = 3'd1;
      units_o = 4'(bin_ext - 7'd10);
    end
  end

endmodule
`default_nettype wire

// File: rtl/clock_keeper.sv
`default_nettype none
// ============================================================================
//  Module      : clock_keeper
//  Description : Free-running hh:mm:ss timekeeper with loadable time/alarm,
//                BCD time digits and an alarm ring FSM with stop and timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_keeper
  import clock_pkg::*;
#(
  parameter int SEC_PER_MIN = 60,
  parameter int RING_TICKS  = 60
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick_1hz,
  input  logic                 load_time,
  input  logic                 load_alarm,
  input  logic [HOURS_W-1:0]   new_time_hours,
  input  logic [MINUTES_W-1:0] new_time_minutes,
  input  logic [HOURS_W-1:0]   new_alarm_hours,
  input  logic [MINUTES_W-1:0] new_alarm_minutes,
  input  logic                 alarm_enable,
  input  logic                 alarm_stop,
  output logic [HOURS_W-1:0]   time_hours,
  output logic [MINUTES_W-1:0] time_minutes,
  output logic [SECONDS_W-1:0] time_seconds,
  output logic [HOURS_W-1:0]   alarm_hours,
  output logic [MINUTES_W-1:0] alarm_minutes,
  output logic [2:0]           time_hours_tens,
  output logic [3:0]           time_hours_units,
  output logic [2:0]           time_minutes_tens,
  output logic [3:0]           time_minutes_units,
  output logic                 alarm_ringing
);

  localparam logic [SECONDS_W-1:0]  SEC_LAST  = SECONDS_W'(SEC_PER_MIN - 1);
  localparam logic [RING_CNT_W-1:0] RING_LAST = RING_CNT_W'(RING_TICKS - 1);

  logic [HOURS_W-1:0]    hours_q,         hours_d;
  logic [MINUTES_W-1:0]  minutes_q,       minutes_d;
  logic [SECONDS_W-1:0]  seconds_q,       seconds_d;
  logic [HOURS_W-1:0]    alarm_hours_q,   alarm_hours_d;
  logic [MINUTES_W-1:0]  alarm_minutes_q, alarm_minutes_d;
  alarm_state_e          state_q;
  logic [RING_CNT_W-1:0] ring_cnt_q;
  logic                  ringing_q;
  logic                  match;

  // Time next-state: a valid load wins over the tick; an invalid load is
  // treated as if it never happened.
  always_comb begin
    hours_d   = hours_q;
    minutes_d = minutes_q;
    seconds_d = seconds_q;
    if (load_time && hm_valid(new_time_hours, new_time_minutes)) begin
      hours_d   = new_time_hours;
      minutes_d = new_time_minutes;
      seconds_d = '0;
    end else if (tick_1hz) begin
      if (seconds_q == SEC_LAST) begin
        seconds_d = '0;
        if (minutes_q == MINUTES_MAX) begin
          minutes_d = '0;
          hours_d   = (hours_q == HOURS_MAX) ? '0 : hours_q + 5'd1;
        end else begin
          minutes_d = minutes_q + 6'd1;
        end
      end else begin
        seconds_d = seconds_q + 6'd1;
      end
    end
  end

  // Alarm next-state: independent of the time load, same validity rule.
  always_comb begin
    alarm_hours_d   = alarm_hours_q;
    alarm_minutes_d = alarm_minutes_q;
    if (load_alarm && hm_valid(new_alarm_hours, new_alarm_minutes)) begin
      alarm_hours_d   = new_alarm_hours;
      alarm_minutes_d = new_alarm_minutes;
    end
  end

  // Time and alarm storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hours_q         <= '0;
      minutes_q       <= '0;
      seconds_q       <= '0;
      alarm_hours_q   <= '0;
      alarm_minutes_q <= '0;
    end else begin
      hours_q         <= hours_d;
      minutes_q       <= minutes_d;
      seconds_q       <= seconds_d;
      alarm_hours_q   <= alarm_hours_d;
      alarm_minutes_q <= alarm_minutes_d;
    end
  end

  // Compared against registered values so the ring starts one cycle after
  // the time/alarm registers first agree.
  assign match = alarm_enable && (hours_q == alarm_hours_q) &&
                 (minutes_q == alarm_minutes_q);

  // Alarm ring FSM; alarm_ringing is registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ring_cnt_q <= '0;
      ringing_q  <= 1'b0;
    end else if (!alarm_enable) begin
      state_q    <= IDLE;
      ring_cnt_q <= '0;
      ringing_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (match) begin
            state_q    <= RINGING;
            ring_cnt_q <= '0;
            ringing_q  <= 1'b1;
          end
        end
        RINGING: begin
          if (!match) begin
            state_q   <= IDLE;
            ringing_q <= 1'b0;
          end else if (alarm_stop || (tick_1hz && ring_cnt_q == RING_LAST)) begin
            state_q   <= SILENCED;
            ringing_q <= 1'b0;
          end else if (tick_1hz) begin
            ring_cnt_q <= ring_cnt_q + 8'd1;
          end
        end
        SILENCED: begin
          // Stay quiet for the rest of the matching minute.
          if (!match) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          ring_cnt_q <= '0;
          ringing_q  <= 1'b0;
        end
      endcase
    end
  end

  assign time_hours    = hours_q;
  assign time_minutes  = minutes_q;
  assign time_seconds  = seconds_q;
  assign alarm_hours   = alarm_hours_q;
  assign alarm_minutes = alarm_minutes_q;
  assign alarm_ringing = ringing_q;

  clock_digit_split #(.W(HOURS_W)) u_hours_digits (
    .bin_i   (hours_q),
    .tens_o  (time_hours_tens),
    .units_o (time_hours_units)
  );

  clock_digit_split #(.W(MINUTES_W)) u_minutes_digits (
    .bin_i   (minutes_q),
    .tens_o  (time_minutes_tens),
    .units_o (time_minutes_units)
  );

endmodule
`default_nettype wire

// File: tb/tb_clock_keeper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clock_keeper
//  Description : Directed plus randomized bench for clock_keeper against a
//                seconds-of-day / ring-flag reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_keeper;

  localparam int SPM   = 4;
  localparam int RT    = 3;
  localparam int DAY_S = 24 * 60 * SPM;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1hz = 1'b0, load_time = 1'b0, load_alarm = 1'b0;
  logic [4:0] new_time_hours = '0, new_alarm_hours = '0;
  logic [5:0] new_time_minutes = '0, new_alarm_minutes = '0;
  logic       alarm_enable = 1'b0, alarm_stop = 1'b0;
  logic [4:0] time_hours, alarm_hours;
  logic [5:0] time_minutes, time_seconds, alarm_minutes;
  logic [2:0] time_hours_tens, time_minutes_tens;
  logic [3:0] time_hours_units, time_minutes_units;
  logic       alarm_ringing;

  int checks = 0;
  int errors = 0;

  // Reference model: time as seconds since midnight, alarm as h/m,
  // ring behaviour as "ringing" / "already silenced this minute" flags.
  int m_total, m_ah, m_am, m_ring, m_sil, m_cnt;

  clock_keeper #(.SEC_PER_MIN(SPM), .RING_TICKS(RT)) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
    .load_time(load_time), .load_alarm(load_alarm),
    .new_time_hours(new_time_hours), .new_time_minutes(new_time_minutes),
    .new_alarm_hours(new_alarm_hours), .new_alarm_minutes(new_alarm_minutes),
    .alarm_enable(alarm_enable), .alarm_stop(alarm_stop),
    .time_hours(time_hours), .time_minutes(time_minutes),
    .time_seconds(time_seconds), .alarm_hours(alarm_hours),
    .alarm_minutes(alarm_minutes),
    .time_hours_tens(time_hours_tens), .time_hours_units(time_hours_units),
    .time_minutes_tens(time_minutes_tens), .time_minutes_units(time_minutes_units),
    .alarm_ringing(alarm_ringing)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_total = 0; m_ah = 0; m_am = 0; m_ring = 0; m_sil = 0; m_cnt = 0;
  endtask

  task automatic check_all(input string name);
    int h, m, s;
    h = m_total / (60 * SPM);
    m = (m_total / SPM) % 60;
    s = m_total % SPM;
    chk({name, ".hours"},   32'(time_hours),   h);
    chk({name, ".minutes"}, 32'(time_minutes), m);
    chk({name, ".seconds"}, 32'(time_seconds), s);
    chk({name, ".al_h"},    32'(alarm_hours),  m_ah);
    chk({name, ".al_m"},    32'(alarm_minutes), m_am);
    chk({name, ".h_tens"},  32'(time_hours_tens),    h / 10);
    chk({name, ".h_units"}, 32'(time_hours_units),   h % 10);
    chk({name, ".m_tens"},  32'(time_minutes_tens),  m / 10);
    chk({name, ".m_units"}, 32'(time_minutes_units), m % 10);
    chk({name, ".ringing"}, 32'(alarm_ringing), m_ring);
  endtask

  // One clock cycle: drive inputs, advance the model, check after the edge.
  task automatic step(input string name, input bit tk, input bit lt, input int th,
                      input int tm, input bit la, input int ah, input int am,
                      input bit en, input bit stp);
    bit match;
    tick_1hz = tk; load_time = lt; load_alarm = la;
    new_time_hours = 5'(th); new_time_minutes = 6'(tm);
    new_alarm_hours = 5'(ah); new_alarm_minutes = 6'(am);
    alarm_enable = en; alarm_stop = stp;

    match = en && (m_total / (60 * SPM) == m_ah) && ((m_total / SPM) % 60 == m_am);
    if (!match) begin
      m_ring = 0; m_sil = 0;
    end else if (m_ring == 1) begin
      if (stp || (tk && m_cnt == RT - 1)) begin
        m_ring = 0; m_sil = 1;
      end else if (tk) begin
        m_cnt++;
      end
    end else if (m_sil == 0) begin
      m_ring = 1; m_cnt = 0;
    end

    if (lt && th <= 23 && tm <= 59) m_total = (th * 60 + tm) * SPM;
    else if (tk) m_total = (m_total + 1) % DAY_S;
    if (la && ah <= 23 && am <= 59) begin
      m_ah = ah; m_am = am;
    end

    @(posedge clk);
    #1;
    check_all(name);
  endtask

  initial begin
    int th, tm, ah, am;
    bit tk, lt, la, en, stp;

    // Reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b0;

    // Day wrap: 23:59:03 -> 00:00:00
    step("wrap_load", 0, 1, 23, 59, 0, 0, 0, 0, 0);
    for (int i = 0; i < SPM; i++) step("wrap_tick", 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Load beats tick; invalid load ignored
    step("load_tick", 1, 1, 12, 34, 0, 0, 0, 0, 0);
    step("load_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("load_bad_h", 0, 1, 24, 10, 0, 0, 0, 0, 0);
    step("load_bad_m", 0, 1, 5, 60, 0, 0, 0, 0, 0);
    step("alarm_bad", 0, 0, 0, 0, 1, 7, 61, 0, 0);

    // Alarm fire at 07:00
    step("al_load", 0, 1, 6, 59, 1, 7, 0, 1, 0);
    for (int i = 0; i < SPM - 1; i++) step("al_pre", 1, 0, 0, 0, 0, 0, 0, 1, 0);
    step("al_roll", 1, 0, 0, 0, 0, 0, 0, 1, 0);
    step("al_ring", 0, 0, 0, 0, 0, 0, 0, 1, 0);

    // Stop, stay silent through the minute, re-arm after 07:01
    step("stop", 0, 0, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < SPM - 1; i++) step("silent", 1, 0, 0, 0, 0, 0, 0, 1, 0);
    step("to_0701", 1, 0, 0, 0, 0, 0, 0, 1, 0);
    step("rearm_ld", 0, 1, 7, 0, 0, 0, 0, 1, 0);
    step("rearm", 0, 0, 0, 0, 0, 0, 0, 1, 0);

    // Timeout after RT ticks
    for (int i = 0; i < RT; i++) step("timeout", 1, 0, 0, 0, 0, 0, 0, 1, 0);
    step("to_0701b", 1, 0, 0, 0, 0, 0, 0, 1, 0);

    // Stop coinciding with the final timeout tick
    step("both_ld", 0, 1, 7, 0, 0, 0, 0, 1, 0);
    step("both_rg", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < RT - 1; i++) step("both_tk", 1, 0, 0, 0, 0, 0, 0, 1, 0);
    step("both", 1, 0, 0, 0, 0, 0, 0, 1, 1);

    // Disable forces idle
    step("dis_ld", 0, 1, 7, 0, 0, 0, 0, 1, 0);
    step("dis_rg", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("disable", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Async reset mid-ring
    step("ar_ld", 0, 1, 7, 0, 0, 0, 0, 1, 0);
    step("ar_rg", 1, 0, 0, 0, 0, 0, 0, 1, 0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    #1 reset = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      tk  = ($urandom_range(0, 2) == 0);
      lt  = ($urandom_range(0, 15) == 0);
      la  = ($urandom_range(0, 25) == 0);
      en  = ($urandom_range(0, 15) != 0);
      stp = ($urandom_range(0, 9) == 0);
      ah  = int'($urandom_range(0, 23));
      am  = int'($urandom_range(0, 59));
      if ($urandom_range(0, 3) == 0) ah = int'($urandom_range(24, 31));
      if ($urandom_range(0, 1) == 0) begin
        th = m_ah; tm = m_am;
      end else begin
        th = int'($urandom_range(0, 31));
        tm = int'($urandom_range(0, 63));
      end
      if (lt && (th > 23 || tm > 59)) tk = 1'b0;
      step("rand", tk, lt, th, tm, la, ah, am, en, stp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
